// File: rtl/ntt_pkg.sv
// ntt_pkg: shared defaults, FSM states and write-back bundle for the NTT core.
package ntt_pkg;
  localparam int NTT_N = 256;
  localparam int NTT_LOGN = 8;
  localparam int NTT_BF_LAT = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [NTT_LOGN-1:0] addr_t;
  typedef struct packed {
    logic  vld;
    addr_t a0;
    addr_t b0;
    addr_t a1;
    addr_t b1;
  } wb_t;
endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: fixed-depth shift register carrying the write-back bundle.
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int W     = $bits(wb_t),
  parameter int DEPTH = NTT_BF_LAT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/posedge_detection.sv
// posedge_detection: two-flop rising-edge detector, one-cycle pulse per edge.
module posedge_detection (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);
  logic q1, q2;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {q1, q2} <= 2'b00;
    else {q1, q2} <= {din, q1};
  assign pulse = q1 & ~q2;
endmodule

// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler: walks all NTT stages issuing two butterflies per cycle,
// with drain cycles between stages so reads never overtake write-backs.
module ntt_bf_scheduler
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int LOGN   = NTT_LOGN,
  parameter int BF_LAT = NTT_BF_LAT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            issue_vld,
  output logic [LOGN-1:0] rd0_a,
  output logic [LOGN-1:0] rd0_b,
  output logic [LOGN-1:0] rd1_a,
  output logic [LOGN-1:0] rd1_b,
  output logic [LOGN-1:0] tw0,
  output logic [LOGN-1:0] tw1,
  output logic            wb_vld,
  output logic [LOGN-1:0] wr0_a,
  output logic [LOGN-1:0] wr0_b,
  output logic [LOGN-1:0] wr1_a,
  output logic [LOGN-1:0] wr1_b
);
  localparam int SW = $clog2(LOGN) + 1;
  localparam int CW = LOGN - 2;
  localparam int DW = $clog2(BF_LAT + 1);
  localparam int WBW = 4 * LOGN + 1;
  localparam logic [LOGN-1:0] HALF0 = LOGN'(N / 2);
  localparam logic [CW-1:0] CMAX = CW'(N / 4 - 1);
  localparam logic [SW-1:0] SLAST = SW'(LOGN - 1);

  state_t          state;
  logic [SW-1:0]   s;
  logic [CW-1:0]   c;
  logic [DW-1:0]   dcnt;
  logic            pulse;
  logic [LOGN-1:0] u0_a, u0_b, u0_t, u1_a, u1_b, u1_t;
  logic [WBW-1:0]  wb_d, wb_q;

  // half is a power of two: g*2*half + k is j with its high part shifted up one
  function automatic logic [3*LOGN-1:0] bf_addr(input logic [LOGN-1:0] j, input logic [SW-1:0] st);
    logic [LOGN-1:0] half, mask, a;
    half = HALF0 >> st;
    mask = half - 1'b1;
    a    = ((j & ~mask) << 1) | (j & mask);
    return {a, a | half, (LOGN'(1) << st) + (j >> (SLAST - st))};
  endfunction

  posedge_detection u_start_det (
    .clk  (clk),
    .rstn (rstn),
    .din  (start),
    .pulse(pulse)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      s     <= '0;
      c     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (pulse) begin
          state <= RUN;
          s     <= '0;
          c     <= '0;
        end
        RUN: if (!stall) begin
          c <= c + 1'b1;
          if (c == CMAX) begin
            state <= DRAIN;
            dcnt  <= DW'(BF_LAT);
          end
        end
        DRAIN: begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == DW'(1)) begin
            if (s == SLAST) state <= DONE;
            else begin
              state <= RUN;
              s     <= s + 1'b1;
              c     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == DONE;
  assign issue_vld = (state == RUN) && !stall;
  assign {u0_a, u0_b, u0_t} = bf_addr({1'b0, c, 1'b0}, s);
  assign {u1_a, u1_b, u1_t} = bf_addr({1'b0, c, 1'b1}, s);
  assign rd0_a = issue_vld ? u0_a : '0;
  assign rd0_b = issue_vld ? u0_b : '0;
  assign rd1_a = issue_vld ? u1_a : '0;
  assign rd1_b = issue_vld ? u1_b : '0;
  assign tw0   = issue_vld ? u0_t : '0;
  assign tw1   = issue_vld ? u1_t : '0;

  assign wb_d = {issue_vld, rd0_a, rd0_b, rd1_a, rd1_b};

  ntt_wb_delay #(
    .W    (WBW),
    .DEPTH(BF_LAT)
  ) u_wb_delay (
    .clk (clk),
    .rstn(rstn),
    .d   (wb_d),
    .q   (wb_q)
  );

  assign {wb_vld, wr0_a, wr0_b, wr1_a, wr1_b} = wb_q;
endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// tb_ntt_bf_scheduler: random-start/stall bench for the scheduler at N=16 and N=256,
// checked against a stage/butterfly address model and a write-back scoreboard.
module tb_ntt_bf_scheduler;
  typedef struct packed {
    logic            v;
    logic [3:0][7:0] r;
    logic [1:0][7:0] t;
  } iss_t;

  logic clk = 1'b0, rstn = 1'b0, st16 = 1'b0, st256 = 1'b0, stall = 1'b0, sel = 1'b0;
  always #5 clk = ~clk;

  logic       b16, d16, iv16, wv16, b256, d256, iv256, wv256;
  logic [3:0] r16 [4], t16 [2], w16 [4];
  logic [7:0] r256 [4], t256 [2], w256 [4];

  ntt_bf_scheduler #(.N(16), .LOGN(4), .BF_LAT(2)) u_dut16 (
    .clk(clk), .rstn(rstn), .start(st16), .stall(stall), .busy(b16), .done(d16),
    .issue_vld(iv16), .rd0_a(r16[0]), .rd0_b(r16[1]), .rd1_a(r16[2]), .rd1_b(r16[3]),
    .tw0(t16[0]), .tw1(t16[1]), .wb_vld(wv16),
    .wr0_a(w16[0]), .wr0_b(w16[1]), .wr1_a(w16[2]), .wr1_b(w16[3])
  );

  ntt_bf_scheduler u_dut256 (
    .clk(clk), .rstn(rstn), .start(st256), .stall(stall), .busy(b256), .done(d256),
    .issue_vld(iv256), .rd0_a(r256[0]), .rd0_b(r256[1]), .rd1_a(r256[2]), .rd1_b(r256[3]),
    .tw0(t256[0]), .tw1(t256[1]), .wb_vld(wv256),
    .wr0_a(w256[0]), .wr0_b(w256[1]), .wr1_a(w256[2]), .wr1_b(w256[3])
  );

  logic            m_busy, m_done, m_iv, m_wv;
  logic [3:0][7:0] m_r, m_w;
  logic [1:0][7:0] m_t;
  always_comb begin
    m_busy = sel ? b256 : b16;
    m_done = sel ? d256 : d16;
    m_iv   = sel ? iv256 : iv16;
    m_wv   = sel ? wv256 : wv16;
    for (int i = 0; i < 4; i++) begin
      m_r[i] = sel ? r256[i] : {4'h0, r16[i]};
      m_w[i] = sel ? w256[i] : {4'h0, w16[i]};
    end
    for (int i = 0; i < 2; i++) m_t[i] = sel ? t256[i] : {4'h0, t16[i]};
  end

  int   vectors = 0, errs = 0, lat = 2, n_busy = 0, n_done = 0, n_gap = 0;
  int   pend [256];
  iss_t exq [$], obs [$], hist [$];
  iss_t cur, e, h;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected issue stream straight from the stage/butterfly arithmetic
  task automatic load_ref(input int n, input int logn);
    iss_t x;
    for (int s = 0; s < logn; s++)
      for (int c = 0; c < n / 4; c++) begin
        x = '0;
        x.v = 1'b1;
        for (int u = 0; u < 2; u++) begin
          int j, half, g, k, a;
          j = 2 * c + u;
          half = n >> (s + 1);
          g = j / half;
          k = j % half;
          a = 2 * g * half + k;
          x.r[2*u]   = 8'(a);
          x.r[2*u+1] = 8'(a + half);
          x.t[u]     = 8'((1 << s) + g);
        end
        exq.push_back(x);
      end
  endtask

  always @(negedge clk) begin
    cur.v = m_iv;
    cur.r = m_r;
    cur.t = m_t;
    if (!rstn) begin
      chk("reset_out", 64'({m_busy, m_done, m_iv, m_wv, |m_r, |m_t, |m_w}), 64'd0);
      hist.delete();
      for (int i = 0; i < lat; i++) hist.push_back('0);
      for (int i = 0; i < 256; i++) pend[i] = 0;
    end else begin
      if (m_busy) n_busy++;
      if (m_busy && !m_iv) n_gap++;
      if (m_done) begin
        n_done++;
        chk("done_busy", 64'(m_busy), 64'd0);
      end
      if (m_iv) for (int i = 0; i < 4; i++) chk("hazard", 64'(pend[cur.r[i]]), 64'd0);
      if (m_wv) for (int i = 0; i < 4; i++) pend[m_w[i]]--;
      if (m_iv) begin
        for (int i = 0; i < 4; i++) pend[cur.r[i]]++;
        obs.push_back(cur);
        if (exq.size() == 0) chk("extra_issue", 64'd1, 64'd0);
        else begin
          e = exq.pop_front();
          chk("rd_tw", 64'({cur.r, cur.t}), 64'({e.r, e.t}));
        end
      end
      hist.push_back(cur);
      h = hist.pop_front();
      chk("wb_delay", 64'({m_wv, m_w}), 64'({h.v, h.r}));
    end
  end

  task automatic clr();
    n_busy = 0;
    n_done = 0;
    n_gap = 0;
    obs.delete();
    exq.delete();
  endtask

  task automatic pulse(input logic big, input int len);
    @(posedge clk);
    #1 if (big) st256 = 1'b1; else st16 = 1'b1;
    repeat (len) @(posedge clk);
    #1 begin st16 = 1'b0; st256 = 1'b0; end
  endtask

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim && n_done == 0; k++) @(posedge clk);
    chk("done_seen", 64'(n_done != 0), 64'd1);
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 200 && obs.size() < n; k++) @(posedge clk);
    chk("obs_reached", 64'(obs.size() >= n), 64'd1);
  endtask

  task automatic fin_chk(input int busy_exp, input int gap_exp);
    chk("busy_cycles", 64'(n_busy), 64'(busy_exp));
    chk("gap_cycles", 64'(n_gap), 64'(gap_exp));
    chk("done_count", 64'(n_done), 64'd1);
    chk("ref_left", 64'(exq.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    // single transform, with fixed-point spot checks on stage 0 and stage 3
    clr();
    load_ref(16, 4);
    pulse(1'b0, 1 + 32'($urandom_range(0, 3)));
    wait_done(100);
    fin_chk(24, 8);
    chk("obs_count", 64'(obs.size()), 64'd16);
    chk("st0_first", 64'({obs[0].r, obs[0].t}), {16'h0, 8'd9, 8'd1, 8'd8, 8'd0, 8'd1, 8'd1});
    chk("st3_first", 64'({obs[12].r, obs[12].t}), {16'h0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9, 8'd8});
    chk("last_iss", 64'({obs[15].r[3], obs[15].r[2], obs[15].t[1]}), 64'({8'd15, 8'd14, 8'd15}));
    // 3-cycle stall in the middle of stage 1
    clr();
    load_ref(16, 4);
    pulse(1'b0, 1);
    wait_obs(6);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(100);
    fin_chk(27, 11);
    // start held high for 100 cycles runs once
    clr();
    load_ref(16, 4);
    pulse(1'b0, 100);
    repeat (10) @(posedge clk);
    fin_chk(24, 8);
    // a second rising edge while busy is ignored
    clr();
    load_ref(16, 4);
    pulse(1'b0, 2);
    repeat (32'($urandom_range(2, 8))) @(posedge clk);
    pulse(1'b0, 2);
    wait_done(100);
    repeat (30) @(posedge clk);
    fin_chk(24, 8);
    // reset while draining stage 0
    clr();
    load_ref(16, 4);
    pulse(1'b0, 1);
    wait_obs(4);
    #1 rstn = 1'b0;
    #1 chk("rst_async", 64'({b16, d16, iv16, wv16, |{r16[0], r16[1], r16[2], r16[3]},
                              |{w16[0], w16[1], w16[2], w16[3]}}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (30) @(posedge clk);
    chk("no_done_rst", 64'(n_done), 64'd0);
    // fresh start after reset
    clr();
    load_ref(16, 4);
    pulse(1'b0, 1);
    wait_done(100);
    fin_chk(24, 8);
    // default configuration
    #1 begin sel = 1'b1; lat = 4; rstn = 1'b0; end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clr();
    load_ref(256, 8);
    pulse(1'b1, 1 + 32'($urandom_range(0, 3)));
    wait_done(1000);
    fin_chk(544, 32);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ntt_bf_scheduler.md
# ntt_bf_scheduler

Sequencing controller for the two parallel simplified butterfly units of the NTT core. On a start request it walks all log2(N) Cooley-Tukey stages and issues two butterflies per cycle: operand-pair addresses for each unit plus the twiddle index. It also produces the matching write-back addresses after the fixed butterfly latency. Between stages it inserts drain cycles so that no read overtakes a pending write-back. It sits between the top-level host handshake and the coefficient RAM, twiddle ROM and butterfly pipelines.

## Interface
- N, 256, transform length; power of two, N >= 8.
- LOGN, 8, log2(N); also the address and twiddle-index width.
- BF_LAT, 4, butterfly pipeline depth in cycles from issue to write-back; BF_LAT >= 1.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  level request; only its rising edge is used.
- stall  in  1  suppresses issue while in RUN.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the transform completes.
- issue_vld  out  1  read addresses and twiddle indices are valid this cycle.
- rd0_a, rd0_b, rd1_a, rd1_b  out  LOGN each  operand addresses for unit 0 and unit 1.
- tw0, tw1  out  LOGN each  twiddle ROM index for unit 0 and unit 1.
- wb_vld  out  1  issue_vld delayed by BF_LAT.
- wr0_a, wr0_b, wr1_a, wr1_b  out  LOGN each  rd* addresses delayed by BF_LAT.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- Start detection is a two-flop rising-edge detector on start. Its pulse is honoured only in IDLE and is ignored in every other state.
- IDLE→RUN on the pulse. The stage counter s and the issue counter c both clear to 0.
- RUN with stall=0: issue_vld=1 and c increments. With stall=1: issue_vld=0 and all counters hold.
- Butterfly index: unit 0 takes j=2c, unit 1 takes j=2c+1, for c in 0..N/4-1.
- Address arithmetic per unit, for stage s:
  - half = N>>(s+1)
  - g = j/half, k = j%half
  - rd_a = 2·g·half + k, rd_b = rd_a + half
  - tw = (1<<s) + g
  - All results are unsigned LOGN bits and never overflow; the maximum tw is N-1.
- RUN→DRAIN after the issue with c = N/4-1. The drain counter loads BF_LAT.
- DRAIN counts BF_LAT cycles; stall has no effect. At expiry:
  - if s < LOGN-1: s increments, c clears, and the FSM returns to RUN;
  - otherwise the FSM goes to DONE.
- DONE lasts one cycle with done=1, then IDLE.
- The write-back delay line shifts every cycle regardless of state or stall. Bubbles propagate as wb_vld=0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, delay line and edge-detector flops 0.
- start first sampled high at edge E0 → detector pulse high in cycle E0..E1 → RUN after E1 → first issue_vld in cycle E1..E2.
- Total busy cycles with no stall: LOGN·(N/4 + BF_LAT). Each stall cycle in RUN adds one cycle.
- wb_vld and wr* equal issue_vld and rd* from exactly BF_LAT cycles earlier.
- The first read of stage s+1 occurs at least one cycle after the last write-back of stage s.
- done is asserted the cycle after the final DRAIN cycle; busy is 0 in that cycle.
- Asynchronous reset mid-transform returns immediately to IDLE with all outputs 0 and the delay line flushed. No done is produced.
- A start held high through completion does not retrigger. A new rising edge is required.
- A start edge that coincides with DONE is ignored.

## Structure
- Shared package ntt_pkg holds:
  - the N, LOGN and BF_LAT defaults;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the address and twiddle-index typedef (LOGN bits);
  - the write-back bundle typedef {vld, 4 addresses}.
- Instantiate the existing posedge_detection for start.
- One sub-module, ntt_wb_delay: a BF_LAT-deep shift register carrying the write-back bundle, with async active-low clear.
- Address generation is combinational from s and c inside the top module. Shift and mask operations are used because half is a power of two.

## Test plan
- Run all tests with N=16, LOGN=4, BF_LAT=2 except the last.
- Single transform:
  - start pulse → stage 0 first issue is rd0=(0,8), rd1=(1,9), tw0=tw1=1.
  - busy lasts 4·(4+2)=24 cycles.
  - done is high for exactly one cycle.
- Stage 3 check: first issue is rd0=(0,1) with tw0=8, and rd1=(2,3) with tw1=9. The last issue is rd1=(14,15) with tw1=15.
- Hazard check:
  - the scoreboard confirms no rd address in stage s+1 is issued before its wr in stage s;
  - wr*/wb_vld equal rd*/issue_vld delayed by exactly 2 cycles.
- Stall of 3 cycles mid-stage 1:
  - issue_vld=0 for those 3 cycles, then the sequence resumes unchanged;
  - total busy is 27 cycles;
  - wb_vld shows the same 3-cycle gap.
- Start abuse:
  - start held high for 100 cycles → exactly one transform runs;
  - a second rising edge while busy is ignored;
  - rstn asserted in DRAIN → all outputs 0 immediately, no done;
  - a fresh start after reset completes normally.
- Default-parameter regression (N=256, BF_LAT=4):
  - the scoreboard checks every address and twiddle index against a reference model;
  - total busy is 8·68=544 cycles.
